// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes and write-master FSM encodings

package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ADDR_DATA = 2'b01,
        WAIT_RESP = 2'b10
    } wr_state_e;

endpackage

// File: rtl/axi4_lite_write_master.sv
// rtl/axi4_lite_write_master.sv - single-outstanding AXI4-Lite write initiator with response timeout flag

module axi4_lite_write_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_resp,
    output logic                  timeout_err,
    output logic [ADDR_WIDTH-1:0] AW_ADDR,
    output logic                  AW_VALID,
    input  logic                  AW_READY,
    output logic [DATA_WIDTH-1:0] W_DATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  W_VALID,
    input  logic                  W_READY,
    input  logic [1:0]            B_RESP,
    input  logic                  B_VALID,
    output logic                  B_READY
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        state_d       = state_q;
        aw_addr_d     = aw_addr_q;
        w_data_d      = w_data_q;
        wstrb_d       = wstrb_q;
        aw_valid_d    = aw_valid_q;
        w_valid_d     = w_valid_q;
        rsp_valid_d   = 1'b0;
        rsp_resp_d    = rsp_resp_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    aw_addr_d     = cmd_addr;
                    w_data_d      = cmd_data;
                    wstrb_d       = cmd_strb;
                    aw_valid_d    = 1'b1;
                    w_valid_d     = 1'b1;
                    timeout_err_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                // A dropped VALID doubles as that channel's done flag.
                if (aw_valid_q && AW_READY) aw_valid_d = 1'b0;
                if (w_valid_q && W_READY)   w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (B_VALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = B_RESP;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (TIMEOUT_CYCLES > 0 && state_q != IDLE) begin
            if (cnt_q != CNT_LIMIT) cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_LIMIT) timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            wstrb_q       <= '0;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_resp_q    <= 2'b00;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            aw_addr_q     <= aw_addr_d;
            w_data_q      <= w_data_d;
            wstrb_q       <= wstrb_d;
            aw_valid_q    <= aw_valid_d;
            w_valid_q     <= w_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_resp_q    <= rsp_resp_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !reset;
    assign B_READY     = (state_q == WAIT_RESP);
    assign AW_ADDR     = aw_addr_q;
    assign AW_VALID    = aw_valid_q;
    assign W_DATA      = w_data_q;
    assign WSTRB       = wstrb_q;
    assign W_VALID     = w_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_resp    = rsp_resp_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axi4_lite_write_master.sv
// tb/tb_axi4_lite_write_master.sv - scoreboard bench with a configurable AXI4-Lite slave model

module tb_axi4_lite_write_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_resp;
    logic        timeout_err;
    logic [31:0] AW_ADDR;
    logic        AW_VALID;
    logic        AW_READY = 1'b0;
    logic [31:0] W_DATA;
    logic [3:0]  WSTRB;
    logic        W_VALID;
    logic        W_READY = 1'b0;
    logic [1:0]  B_RESP = 2'b00;
    logic        B_VALID = 1'b0;
    logic        B_READY;

    axi4_lite_write_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .WSTRB(WSTRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        bit          lat_chk;
        int          exp_to;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Slave model configuration and captured payload
    int          aw_dly = 0, w_dly = 0, b_dly = 0;
    bit          w_after_aw = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [31:0] cap_addr = '0, cap_data = '0;
    logic [3:0]  cap_strb = '0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0;

    initial begin : slave
        int aw_cnt, w_cnt, b_cnt;
        bit aw_got, w_got, aw_old, w_old, aw_fire, w_fire, b_fire, aw_stall, w_stall;
        logic [31:0] aw_hold, w_hold;
        logic [3:0]  s_hold;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_got = 0; w_got = 0; aw_fire = 0; w_fire = 0; b_fire = 0; aw_stall = 0; w_stall = 0;
        aw_hold = '0; w_hold = '0; s_hold = '0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                aw_got = 0; w_got = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
                aw_stall = 0; w_stall = 0;
                AW_READY = 0; W_READY = 0; B_VALID = 0;
                continue;
            end
            if (b_fire) begin
                b_fire = 0; B_VALID = 0;
                aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end
            if (aw_fire) check_eq("aw_valid_drop", AW_VALID, 0);
            if (w_fire)  check_eq("w_valid_drop", W_VALID, 0);
            if (aw_stall) begin
                check_eq("aw_valid_held", AW_VALID, 1);
                check_eq("aw_addr_stable", AW_ADDR, aw_hold);
            end
            if (w_stall) begin
                check_eq("w_valid_held", W_VALID, 1);
                check_eq("w_data_stable", {WSTRB, W_DATA}, {s_hold, w_hold});
            end
            aw_fire = 0; w_fire = 0; aw_stall = 0; w_stall = 0;
            aw_old = aw_got; w_old = w_got;

            AW_READY = 0;
            if (AW_VALID && !aw_got) begin
                aw_cnt++;
                if (aw_cnt > aw_dly) begin
                    AW_READY = 1; aw_got = 1; aw_fire = 1;
                    cap_addr = AW_ADDR; aw_hs_cyc = cyc;
                end else begin
                    aw_stall = 1; aw_hold = AW_ADDR;
                end
            end

            W_READY = 0;
            if (W_VALID && !w_got && (!w_after_aw || aw_old)) begin
                w_cnt++;
                if (w_cnt > w_dly) begin
                    W_READY = 1; w_got = 1; w_fire = 1;
                    cap_data = W_DATA; cap_strb = WSTRB; w_hs_cyc = cyc;
                end else begin
                    w_stall = 1; w_hold = W_DATA; s_hold = WSTRB;
                end
            end else if (W_VALID && !w_got) begin
                w_stall = 1; w_hold = W_DATA; s_hold = WSTRB;
            end

            if (aw_old && w_old && !B_VALID) begin
                b_cnt++;
                if (b_cnt > b_dly) begin
                    B_VALID = 1; B_RESP = b_resp_cfg;
                end
            end
            if (B_VALID && B_READY) b_fire = 1;
        end
    end

    initial begin : monitor
        exp_t e;
        bit to_prev;
        int to_rise;
        to_prev = 0; to_rise = 0;
        forever begin
            @(posedge clk); #3;
            if (timeout_err && !to_prev) to_rise = cyc;
            to_prev = timeout_err;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("aw_addr", cap_addr, e.addr);
                    check_eq("w_data", cap_data, e.data);
                    check_eq("w_strb", cap_strb, e.strb);
                    check_eq("rsp_resp", rsp_resp, e.resp);
                    if (e.lat_chk) check_eq("rsp_latency", cyc + 1 - e.acc_cyc, 3);
                    if (e.exp_to == 1) begin
                        check_eq("timeout_err_set", timeout_err, 1);
                        check_eq("timeout_rise_cyc", to_rise - e.acc_cyc, 8);
                    end else if (e.exp_to == 0) begin
                        check_eq("timeout_err_clear", timeout_err, 0);
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] r, input bit lat, input int to,
                        input bit hold_after, input bit chk_b2b);
        exp_t e;
        int n;
        cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            check_eq("cmd_accept_timeout", 0, 1);
            cmd_valid = 0;
            return;
        end
        if (chk_b2b) begin
            check_eq("b2b_accept_in_rsp", rsp_valid, 1);
            check_eq("b2b_no_aw_overlap", AW_VALID, 0);
        end
        e.addr = a; e.data = d; e.strb = s; e.resp = r;
        e.lat_chk = lat; e.exp_to = to; e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!hold_after) cmd_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 100) begin
            @(posedge clk); #4; n++;
        end
        if (sb.size() != 0 || !cmd_ready) check_eq(tag, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic set_slave(input int a, input int w, input int b, input bit war, input logic [1:0] r);
        aw_dly = a; w_dly = w; b_dly = b; w_after_aw = war; b_resp_cfg = r;
    endtask

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_aw_valid", AW_VALID, 0);
        check_eq("rst_w_valid", W_VALID, 0);
        check_eq("rst_b_ready", B_READY, 0);
        check_eq("rst_payload", {AW_ADDR, W_DATA, WSTRB}, 0);
        check_eq("rst_rsp", {rsp_valid, rsp_resp, timeout_err}, 0);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        reset = 0;
        @(posedge clk); #1;
        check_eq("post_rst_cmd_ready", cmd_ready, 1);

        set_slave(0, 0, 0, 0, 2'b00);
        send(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 1, 0, 0, 0);
        wait_idle("t1_done");

        set_slave(1, 0, 0, 1, 2'b00);
        send(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0, 0);
        wait_idle("t2_done");
        check_eq("t2_w_after_aw", w_hs_cyc > aw_hs_cyc, 1);

        set_slave(3, 1, 5, 0, 2'b10);
        send(32'h24, 32'h12345678, 4'h3, 2'b10, 0, 1, 0, 0);
        wait_idle("t3_done");
        check_eq("t3_w_before_aw", aw_hs_cyc - w_hs_cyc, 2);

        set_slave(0, 0, 20, 0, 2'b00);
        send(32'h40, 32'hA5A5_0001, 4'hC, 2'b00, 0, 1, 0, 0);
        wait_idle("t4_done");
        check_eq("t4_err_sticky_idle", timeout_err, 1);
        set_slave(0, 0, 0, 0, 2'b01);
        send(32'h44, 32'h0BAD_F00D, 4'h1, 2'b01, 1, 0, 0, 0);
        check_eq("t4_err_clear_on_accept", timeout_err, 0);
        wait_idle("t4b_done");

        set_slave(0, 0, 6, 0, 2'b11);
        send(32'h80, 32'hCAFE_0080, 4'hF, 2'b11, 0, 2, 0, 0);
        n = 0;
        while (!B_READY && n < 20) begin @(posedge clk); #1; n++; end
        check_eq("t5_reach_wait_resp", B_READY, 1);
        reset = 1;
        @(posedge clk); #1;
        sb.delete();
        check_eq("t5_valids_low", {AW_VALID, W_VALID, B_READY}, 0);
        check_eq("t5_no_rsp", rsp_valid, 0);
        check_eq("t5_cmd_ready_in_rst", cmd_ready, 0);
        reset = 0;
        @(posedge clk); #1;
        check_eq("t5_cmd_ready_after", cmd_ready, 1);
        repeat (10) @(posedge clk);
        #1;

        set_slave(0, 0, 0, 0, 2'b00);
        send(32'h100, 32'h1111_2222, 4'hF, 2'b00, 1, 0, 1, 0);
        send(32'h104, 32'h3333_4444, 4'h5, 2'b00, 1, 0, 0, 1);
        wait_idle("t6_done");

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
